// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired control unit: state encoding,
// opcodes, ALU op codes, control-word bit positions and the control word.
package cpu_ctrl_pkg;

  localparam int OPW      = 5;
  localparam int INCPC_OP = 14;

  typedef enum logic [3:0] {
    S_RESET = 4'd0,
    S_T0    = 4'd1,
    S_T1    = 4'd2,
    S_T2    = 4'd3,
    S_T3    = 4'd4,
    S_T4    = 4'd5,
    S_T5    = 4'd6,
    S_T6    = 4'd7,
    S_T7    = 4'd8,
    S_HALT  = 4'd9
  } state_t;

  // Opcodes, ir[31:27]
  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_AND  = 5'd2;
  localparam logic [4:0] OP_OR   = 5'd3;
  localparam logic [4:0] OP_ADDI = 5'd4;
  localparam logic [4:0] OP_ANDI = 5'd5;
  localparam logic [4:0] OP_ORI  = 5'd6;
  localparam logic [4:0] OP_LD   = 5'd7;
  localparam logic [4:0] OP_LDI  = 5'd8;
  localparam logic [4:0] OP_ST   = 5'd9;
  localparam logic [4:0] OP_BR   = 5'd10;
  localparam logic [4:0] OP_JR   = 5'd11;
  localparam logic [4:0] OP_NOP  = 5'd12;
  localparam logic [4:0] OP_HALT = 5'd13;

  // ALU op codes on Control_Signals
  localparam logic [4:0] ALU_NONE  = 5'd0;
  localparam logic [4:0] ALU_ADD   = 5'd1;
  localparam logic [4:0] ALU_SUB   = 5'd2;
  localparam logic [4:0] ALU_AND   = 5'd3;
  localparam logic [4:0] ALU_OR    = 5'd4;

  // enable[] bit positions
  localparam int EN_ZIN   = 18;
  localparam int EN_YIN   = 19;
  localparam int EN_PCIN  = 20;
  localparam int EN_MDRIN = 21;
  localparam int EN_IRIN  = 24;
  localparam int EN_MARIN = 25;
  localparam int EN_CONIN = 27;

  // busSelect[] bit positions
  localparam int BS_REG = 0;
  localparam int BS_ZLO = 19;
  localparam int BS_PC  = 20;
  localparam int BS_MDR = 21;
  localparam int BS_C   = 23;

  typedef struct packed {
    logic [31:0] enable;
    logic [31:0] bus_select;
    logic [4:0]  alu_op;
    logic        gra;
    logic        grb;
    logic        grc;
    logic        rin;
    logic        rout;
    logic        baout;
    logic        md_read;
    logic        read_ram;
    logic        write_ram;
  } ctrl_word_t;

  // ALU operation used by the register and immediate instruction forms
  function automatic logic [4:0] alu_for_op(input logic [4:0] op);
    case (op)
      OP_ADD, OP_ADDI: alu_for_op = ALU_ADD;
      OP_SUB:          alu_for_op = ALU_SUB;
      OP_AND, OP_ANDI: alu_for_op = ALU_AND;
      OP_OR, OP_ORI:   alu_for_op = ALU_OR;
      default:         alu_for_op = ALU_NONE;
    endcase
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Signal bundle between control_unit (master) and datapath (slave).
// There is no valid/ready handshake: the control word is a Moore decode of
// the current state and holds valid for the whole clock period.
interface control_unit_if;
  logic [31:0] ir;
  logic        con_ff;
  logic [31:0] enable;
  logic [31:0] busSelect;
  logic [4:0]  Control_Signals;
  logic        Gra;
  logic        Grb;
  logic        Grc;
  logic        Rin;
  logic        Rout;
  logic        BAout;
  logic        MD_Read;
  logic        ReadRAM;
  logic        WriteRAM;
  logic        run;
  logic [3:0]  state;

  modport master (
    input  ir, con_ff,
    output enable, busSelect, Control_Signals, Gra, Grb, Grc,
           Rin, Rout, BAout, MD_Read, ReadRAM, WriteRAM, run, state
  );

  modport slave (
    output ir, con_ff,
    input  enable, busSelect, Control_Signals, Gra, Grb, Grc,
           Rin, Rout, BAout, MD_Read, ReadRAM, WriteRAM, run, state
  );
endinterface

// File: rtl/control_decoder.sv
// Purely combinational decode of (state, opcode, con_ff) into the full
// datapath control word.
module control_decoder
  import cpu_ctrl_pkg::*;
#(
  parameter int OPW      = 5,
  parameter int INCPC_OP = 14
) (
  input  state_t         state,
  input  logic [OPW-1:0] opcode,
  input  logic           con_ff,
  output ctrl_word_t     cw,
  output logic           run
);

  logic is_rform;
  logic is_imm;
  logic is_addr;

  assign is_rform = (opcode <= OP_OR);
  assign is_imm   = (opcode == OP_ADDI) || (opcode == OP_ANDI) || (opcode == OP_ORI);
  assign is_addr  = (opcode == OP_LD) || (opcode == OP_LDI) || (opcode == OP_ST);

  // Control word for the current state; everything not named stays 0
  always_comb begin
    cw  = '0;
    run = (state >= S_T0) && (state <= S_T7);
    case (state)
      S_T0: begin
        cw.bus_select[BS_PC]  = 1'b1;
        cw.enable[EN_MARIN]   = 1'b1;
        cw.alu_op             = 5'(INCPC_OP);
        cw.enable[EN_ZIN]     = 1'b1;
      end
      S_T1: begin
        cw.bus_select[BS_ZLO] = 1'b1;
        cw.enable[EN_PCIN]    = 1'b1;
        cw.md_read            = 1'b1;
        cw.read_ram           = 1'b1;
        cw.enable[EN_MDRIN]   = 1'b1;
      end
      S_T2: begin
        cw.bus_select[BS_MDR] = 1'b1;
        cw.enable[EN_IRIN]    = 1'b1;
      end
      S_T3: begin
        if (is_rform || is_imm) begin
          cw.grb = 1'b1; cw.rout = 1'b1; cw.enable[EN_YIN] = 1'b1;
        end else if (is_addr) begin
          cw.grb = 1'b1; cw.baout = 1'b1; cw.enable[EN_YIN] = 1'b1;
        end else if (opcode == OP_BR) begin
          cw.gra = 1'b1; cw.rout = 1'b1; cw.enable[EN_CONIN] = 1'b1;
        end else if (opcode == OP_JR) begin
          cw.gra = 1'b1; cw.rout = 1'b1; cw.enable[EN_PCIN] = 1'b1;
        end
      end
      S_T4: begin
        if (is_rform) begin
          cw.grc = 1'b1; cw.rout = 1'b1;
          cw.alu_op = alu_for_op(opcode); cw.enable[EN_ZIN] = 1'b1;
        end else if (is_imm) begin
          cw.bus_select[BS_C] = 1'b1;
          cw.alu_op = alu_for_op(opcode); cw.enable[EN_ZIN] = 1'b1;
        end else if (is_addr) begin
          cw.bus_select[BS_C] = 1'b1;
          cw.alu_op = ALU_ADD; cw.enable[EN_ZIN] = 1'b1;
        end else if (opcode == OP_BR) begin
          cw.bus_select[BS_PC] = 1'b1; cw.enable[EN_YIN] = 1'b1;
        end
      end
      S_T5: begin
        if (is_rform || is_imm || opcode == OP_LDI) begin
          cw.bus_select[BS_ZLO] = 1'b1; cw.gra = 1'b1; cw.rin = 1'b1;
        end else if (opcode == OP_LD || opcode == OP_ST) begin
          cw.bus_select[BS_ZLO] = 1'b1; cw.enable[EN_MARIN] = 1'b1;
        end else if (opcode == OP_BR) begin
          cw.bus_select[BS_C] = 1'b1;
          cw.alu_op = ALU_ADD; cw.enable[EN_ZIN] = 1'b1;
        end
      end
      S_T6: begin
        if (opcode == OP_LD) begin
          cw.md_read = 1'b1; cw.read_ram = 1'b1; cw.enable[EN_MDRIN] = 1'b1;
        end else if (opcode == OP_ST) begin
          // MDR is loaded from the bus here, so md_read stays 0
          cw.gra = 1'b1; cw.rout = 1'b1; cw.enable[EN_MDRIN] = 1'b1;
        end else if (opcode == OP_BR && con_ff) begin
          cw.bus_select[BS_ZLO] = 1'b1; cw.enable[EN_PCIN] = 1'b1;
        end
      end
      S_T7: begin
        if (opcode == OP_LD) begin
          cw.bus_select[BS_MDR] = 1'b1; cw.gra = 1'b1; cw.rin = 1'b1;
        end else if (opcode == OP_ST) begin
          cw.write_ram = 1'b1;
        end
      end
      default: ;
    endcase
    // Register-file reads drive the bus through the register-file source
    if (cw.rout || cw.baout) cw.bus_select[BS_REG] = 1'b1;
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore control unit: one state per clock through fetch (T0-T2)
// and an opcode-dependent execute sequence (T3-T7), parking in HALT.
module control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int OPW      = 5,
  parameter int INCPC_OP = 14
) (
  input  logic          clk,
  input  logic          clr,
  control_unit_if.master ctl
);

  state_t         state_q;
  state_t         state_d;
  logic [OPW-1:0] opcode;
  ctrl_word_t     cw;
  logic           run;

  assign opcode = ctl.ir[31 -: OPW];

  // State register; clr forces RESET immediately, even mid-instruction
  always_ff @(posedge clk or posedge clr) begin
    if (clr) state_q <= S_RESET;
    else     state_q <= state_d;
  end

  // Next state: fetch is fixed, execute length depends on the opcode
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET: state_d = S_T0;
      S_T0:    state_d = S_T1;
      S_T1:    state_d = S_T2;
      S_T2:    state_d = S_T3;
      S_T3: begin
        if (opcode == OP_HALT)    state_d = S_HALT;
        else if (opcode <= OP_BR) state_d = S_T4;
        else                      state_d = S_T0;
      end
      S_T4:    state_d = S_T5;
      S_T5: begin
        if (opcode == OP_LD || opcode == OP_ST || opcode == OP_BR) state_d = S_T6;
        else                                                      state_d = S_T0;
      end
      S_T6: begin
        if (opcode == OP_LD || opcode == OP_ST) state_d = S_T7;
        else                                    state_d = S_T0;
      end
      S_T7:    state_d = S_T0;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RESET;
    endcase
  end

  control_decoder #(
    .OPW      (OPW),
    .INCPC_OP (INCPC_OP)
  ) u_decoder (
    .state  (state_q),
    .opcode (opcode),
    .con_ff (ctl.con_ff),
    .cw     (cw),
    .run    (run)
  );

  assign ctl.enable          = cw.enable;
  assign ctl.busSelect       = cw.bus_select;
  assign ctl.Control_Signals = cw.alu_op;
  assign ctl.Gra             = cw.gra;
  assign ctl.Grb             = cw.grb;
  assign ctl.Grc             = cw.grc;
  assign ctl.Rin             = cw.rin;
  assign ctl.Rout            = cw.rout;
  assign ctl.BAout           = cw.baout;
  assign ctl.MD_Read         = cw.md_read;
  assign ctl.ReadRAM         = cw.read_ram;
  assign ctl.WriteRAM        = cw.write_ram;
  assign ctl.run             = run;
  assign ctl.state           = state_q;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: instruction-level reference model feeds an
// expected-control-word queue; a monitor pops and compares every cycle.
module tb_control_unit;
  import cpu_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  control_unit_if ctl();

  control_unit dut (
    .clk (clk),
    .clr (clr),
    .ctl (ctl)
  );

  // ---------------- scoreboard state ----------------
  localparam int W = 83;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] stage_q[$];
  int checks = 0;
  int errors = 0;
  event probe_ev;

  // Bit positions straight from the port description
  localparam int EZ = 18, EY = 19, EPC = 20, EMDR = 21, EIR = 24, EMAR = 25, ECON = 27;
  localparam int BZ = 19, BPC = 20, BMDR = 21, BC = 23;
  // Strobe flags, order: Gra Grb Grc Rin Rout BAout MD_Read ReadRAM WriteRAM
  localparam logic [8:0] F_GRA = 9'h100, F_GRB = 9'h080, F_GRC = 9'h040, F_RIN = 9'h020;
  localparam logic [8:0] F_ROUT = 9'h010, F_BAOUT = 9'h008, F_MDRD = 9'h004;
  localparam logic [8:0] F_RDRAM = 9'h002, F_WRRAM = 9'h001;

  function automatic logic [31:0] b1(input int b);
    return 32'(1) << b;
  endfunction

  // One expected cycle into the staging queue
  task automatic stage(input logic [3:0] st, input logic [31:0] en, input logic [31:0] bs,
                       input int alu, input logic [8:0] fl, input logic run);
    logic [31:0] bsx;
    bsx = bs;
    if ((fl & (F_ROUT | F_BAOUT)) != 9'h0) bsx = bsx | 32'h1;
    stage_q.push_back({st, en, bsx, 5'(alu), fl, run});
  endtask

  function automatic logic [W-1:0] idle_word(input logic [3:0] st);
    return {st, 32'h0, 32'h0, 5'h0, 9'h0, 1'b0};
  endfunction

  // Reference model: the cycle-by-cycle steps of one instruction
  task automatic model_instr(input logic [31:0] instr, input logic con);
    int op;
    int alu;
    op = int'(instr[31:27]);
    stage_q.delete();
    stage(S_T0, b1(EMAR) | b1(EZ), b1(BPC), 14, 9'h0, 1'b1);
    stage(S_T1, b1(EPC) | b1(EMDR), b1(BZ), 0, F_MDRD | F_RDRAM, 1'b1);
    stage(S_T2, b1(EIR), b1(BMDR), 0, 9'h0, 1'b1);
    if (op <= 6) begin
      if (op <= 3) alu = op + 1;
      else         alu = (op == 4) ? 1 : (op == 5) ? 3 : 4;
      stage(S_T3, b1(EY), 32'h0, 0, F_GRB | F_ROUT, 1'b1);
      if (op <= 3) stage(S_T4, b1(EZ), 32'h0, alu, F_GRC | F_ROUT, 1'b1);
      else         stage(S_T4, b1(EZ), b1(BC), alu, 9'h0, 1'b1);
      stage(S_T5, 32'h0, b1(BZ), 0, F_GRA | F_RIN, 1'b1);
    end else if (op <= 9) begin
      stage(S_T3, b1(EY), 32'h0, 0, F_GRB | F_BAOUT, 1'b1);
      stage(S_T4, b1(EZ), b1(BC), 1, 9'h0, 1'b1);
      if (op == 8) begin
        stage(S_T5, 32'h0, b1(BZ), 0, F_GRA | F_RIN, 1'b1);
      end else begin
        stage(S_T5, b1(EMAR), b1(BZ), 0, 9'h0, 1'b1);
        if (op == 7) begin
          stage(S_T6, b1(EMDR), 32'h0, 0, F_MDRD | F_RDRAM, 1'b1);
          stage(S_T7, 32'h0, b1(BMDR), 0, F_GRA | F_RIN, 1'b1);
        end else begin
          stage(S_T6, b1(EMDR), 32'h0, 0, F_GRA | F_ROUT, 1'b1);
          stage(S_T7, 32'h0, 32'h0, 0, F_WRRAM, 1'b1);
        end
      end
    end else if (op == 10) begin
      stage(S_T3, b1(ECON), 32'h0, 0, F_GRA | F_ROUT, 1'b1);
      stage(S_T4, b1(EY), b1(BPC), 0, 9'h0, 1'b1);
      stage(S_T5, b1(EZ), b1(BC), 1, 9'h0, 1'b1);
      if (con) stage(S_T6, b1(EPC), b1(BZ), 0, 9'h0, 1'b1);
      else     stage(S_T6, 32'h0, 32'h0, 0, 9'h0, 1'b1);
    end else if (op == 11) begin
      stage(S_T3, b1(EPC), 32'h0, 0, F_GRA | F_ROUT, 1'b1);
    end else begin
      stage(S_T3, 32'h0, 32'h0, 0, 9'h0, 1'b1);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Entry/exit condition: #1 after a rising edge, DUT in T0
  task automatic clr_pulse();
    clr = 1'b1;
    #1;
    exp_q.push_back(idle_word(S_RESET));
    ->probe_ev;
    #1;
    exp_q.push_back(idle_word(S_RESET));
    @(negedge clk);
    #1;
    clr = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [31:0] instr, input logic con);
    int n;
    ctl.ir     = instr;
    ctl.con_ff = con;
    model_instr(instr, con);
    n = stage_q.size();
    foreach (stage_q[i]) exp_q.push_back(stage_q[i]);
    if (instr[31:27] == 5'd13) begin
      for (int i = 0; i < 20; i++) exp_q.push_back(idle_word(S_HALT));
      n = n + 20;
    end
    repeat (n) @(posedge clk);
    #1;
    if (instr[31:27] == 5'd13) clr_pulse();
  endtask

  // ld interrupted by clr during T5
  task automatic run_ld_abort(input logic [31:0] instr);
    ctl.ir     = instr;
    ctl.con_ff = 1'b0;
    model_instr(instr, 1'b0);
    for (int i = 0; i < 6; i++) exp_q.push_back(stage_q[i]);
    repeat (5) @(posedge clk);
    @(negedge clk);
    #1;
    clr = 1'b1;
    #1;
    exp_q.push_back(idle_word(S_RESET));
    ->probe_ev;
    #1;
    exp_q.push_back(idle_word(S_RESET));
    @(negedge clk);
    #1;
    clr = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [W-1:0] obs;
    logic [W-1:0] exp;
    forever begin
      @(negedge clk or probe_ev);
      obs = {ctl.state, ctl.enable, ctl.busSelect, ctl.Control_Signals,
             ctl.Gra, ctl.Grb, ctl.Grc, ctl.Rin, ctl.Rout, ctl.BAout,
             ctl.MD_Read, ctl.ReadRAM, ctl.WriteRAM, ctl.run};
      checks++;
      if (!$onehot0(ctl.busSelect)) begin
        errors++;
        $display("FAIL bus_onehot0 busSelect=%h required at most one bit set", ctl.busSelect);
      end
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        checks++;
        if (obs !== exp) begin
          errors++;
          $display("FAIL ctrl_word state=%0d got=%h want=%h", exp[82:79], obs, exp);
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1);
  end

  // ---------------- main stimulus ----------------
  initial begin
    logic [31:0] instr;
    logic [4:0]  op;
    ctl.ir     = 32'h0;
    ctl.con_ff = 1'b0;
    clr        = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(idle_word(S_RESET));
    @(negedge clk);
    #1;
    clr = 1'b0;
    @(posedge clk);
    #1;

    run_instr(32'h0091_8000, 1'b0);   // add R1,R2,R3
    run_instr(32'h3900_0055, 1'b0);   // ld R2,0x55(R0)
    run_instr(32'h5080_0003, 1'b1);   // br taken
    run_instr(32'h5080_0003, 1'b0);   // br not taken
    run_instr(32'h4880_0010, 1'b0);   // st
    run_ld_abort(32'h3900_0055);      // clr during T5 of ld
    run_instr(32'h6000_0000, 1'b0);   // nop after restart
    run_instr(32'h6800_0000, 1'b0);   // halt, then clr pulse
    run_instr(32'h2000_0007, 1'b0);   // addi
    run_instr(32'h5880_0000, 1'b1);   // jr
    run_instr(32'hF800_0000, 1'b1);   // unassigned opcode 31

    for (int k = 0; k < 80; k++) begin
      op    = 5'($urandom_range(0, 31));
      instr = {op, 27'($urandom)};
      run_instr(instr, 1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain leftover=%0d required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Hardwired Moore control unit that sits directly upstream of `datapath`.
- Drives every control input `datapath` exposes: `enable`, `busSelect`, `Control_Signals`, `Gra`/`Grb`/`Grc`, `Rin`/`Rout`/`BAout`, `MD_Read`, `ReadRAM`, `WriteRAM`.
- Sequences fetch, decode and execute one state per clock.
- Replaces the hand-driven control sequences in the datapath benches; consumes `ir` and the CON flip-flop output that `datapath` produces.

Parameters:
- `OPW`, 5, opcode width; opcode is `ir[31:27]`.
- `INCPC_OP`, 14, `Control_Signals` code for PC+1.

Ports:
- `clk`  in  1  system clock, rising edge.
- `clr`  in  1  asynchronous active-high reset.
- `ir`  in  32  instruction register contents from `datapath`.
- `con_ff`  in  1  branch condition flip-flop output from `datapath`.
- `enable`  out  32  register load enables: [18] Zin, [19] Yin, [20] PCin, [21] MDRin, [24] IRin, [25] MARin, [27] CONin; all other bits 0.
- `busSelect`  out  32  bus source select: [0] register file, [19] ZLOout, [20] PCout, [21] MDRout, [23] Cout; all other bits 0.
- `Control_Signals`  out  5  ALU op: 0 none, 1 ADD, 2 SUB, 3 AND, 4 OR, 14 INCPC.
- `Gra`, `Grb`, `Grc`  out  1 each  register field select (ra `ir[26:23]`, rb `ir[22:19]`, rc `ir[18:15]`).
- `Rin`, `Rout`, `BAout`  out  1 each  register file write / read / base-address read (R0 reads 0). `Rout` and `BAout` both also assert `busSelect[0]`.
- `MD_Read`  out  1  MDR mux selects memory (1) or bus (0).
- `ReadRAM`, `WriteRAM`  out  1 each  memory strobes.
- `run`  out  1  1 while executing; 0 in RESET and HALT.
- `state`  out  4  current state, for debug.

Behaviour:
- States: RESET, T0..T7, HALT. Outputs are a combinational decode of the state register, opcode and `con_ff` only. Every unlisted output is 0.
- `clr`=1 forces RESET immediately, mid-instruction included: all outputs 0, `run`=0. First clock edge with `clr`=0 moves to T0.
- Fetch, common to all instructions:
  - T0: PCout, MARin, `Control_Signals`=INCPC, Zin.
  - T1: ZLOout, PCin, `MD_Read`, `ReadRAM`, MDRin.
  - T2: MDRout, IRin.
  - T3 onward: `ir` is valid; decode on `ir[31:27]`.
- Sequences, each returning to T0 after the last listed state:
  - add 0, sub 1, and 2, or 3:
    - T3: Grb, Rout, Yin.
    - T4: Grc, Rout, op, Zin.
    - T5: ZLOout, Gra, Rin.
  - addi 4, andi 5, ori 6:
    - T3: Grb, Rout, Yin.
    - T4: Cout, op, Zin.
    - T5: ZLOout, Gra, Rin.
  - ld 7:
    - T3: Grb, BAout, Yin.
    - T4: Cout, ADD, Zin.
    - T5: ZLOout, MARin.
    - T6: `MD_Read`, `ReadRAM`, MDRin.
    - T7: MDRout, Gra, Rin.
  - ldi 8: T3 and T4 as ld; T5: ZLOout, Gra, Rin.
  - st 9:
    - T3 to T5 as ld.
    - T6: Gra, Rout, MDRin, `MD_Read`=0.
    - T7: `WriteRAM`.
  - br 10:
    - T3: Gra, Rout, CONin.
    - T4: PCout, Yin.
    - T5: Cout, ADD, Zin.
    - T6: if `con_ff`=1, ZLOout and PCin; otherwise no outputs. `con_ff` is sampled combinationally in T6.
  - jr 11: T3: Gra, Rout, PCin.
  - nop 12, and every unassigned opcode (14..31): T3 asserts nothing.
  - halt 13: T3 asserts nothing, then HALT. HALT holds, `run`=0, all outputs 0; leave only via `clr`.
- ALU op mapping for R and immediate forms:
  - add and addi → ADD.
  - sub → SUB.
  - and and andi → AND.
  - or and ori → OR.
- Cycle counts including fetch:
  - R and immediate forms, ldi: 6.
  - ld, st: 8.
  - br: 7.
  - jr, nop: 4.
  - halt: 4, then parks in HALT.
- Never assert two `busSelect` bits in the same state.

Decomposition:
- Package `cpu_ctrl_pkg` holds:
  - state encoding;
  - opcode constants;
  - ALU op codes;
  - `enable` / `busSelect` bit-index constants.
- Split: `control_unit` holds the state register and next-state logic. Sub-module `control_decoder` (purely combinational: state, opcode, `con_ff` → full control word) holds the output decode.

Test Plan:
- Pulse `clr` then release; `ir` = add R1,R2,R3 (0x00918000) → T0 shows `busSelect`[20], `enable`[25], `enable`[18], `Control_Signals`=14. T4 shows Grc, Rout, `Control_Signals`=1. T5 shows Gra, Rin. Back in T0 on cycle 7.
- ld R2,0x55(R0) (0x39000055) → T3 BAout, T5 `enable`[25]; T6 `ReadRAM`=`MD_Read`=1; T7 `busSelect`[21], Gra, Rin; 8 cycles total.
- br with `con_ff`=1 and again with `con_ff`=0 → T6 asserts `busSelect`[19] and `enable`[20] only when `con_ff`=1; next state T0 in both cases.
- st (opcode 9) → T6 `MD_Read`=0 with `enable`[21]=1; T7 `WriteRAM`=1 for exactly one cycle.
- halt (0x68000000) → `run` drops to 0 after T3 and all outputs stay 0 for 20 cycles. `clr` pulse → RESET, then T0.
- Assert `clr` asynchronously in T5 of ld → outputs 0 within the same cycle with no clock edge; fetch restarts at T0 after release.
- Every cycle of every test: `busSelect` has at most one bit set (`$onehot0` assertion).
